// File: rtl/ixc_pipe_21.sv
// ixc_pipe_21: two-entry skid buffer for a fixed 21-bit data word (main register drives L, skid catches overflow).
// Latency: one cycle from an upstream accept to the word appearing on L with LV=1.
// Backpressure: RR is decoded from state only (low in TWO and while RST is high); L is held stable while LV=1 and LR=0.
// Optional: define IXC_PIPE_STALLCNT_EN to add the 8-bit saturating STALL counter port.
module ixc_pipe_21 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [20:0] R,
  input  logic        RV,
  output logic        RR,
  output logic [20:0] L,
  output logic        LV,
  input  logic        LR
`ifdef IXC_PIPE_STALLCNT_EN
  ,
  output logic [7:0]  STALL
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      r_state;
  logic [20:0] r_main;
  logic [20:0] r_skid;
  logic        r_lv;

  logic        w_acc;
  logic        w_cons;

  // Ready comes from the registered state only, so there is no combinational path from LR.
  assign RR     = !RST && (r_state != S_TWO);
  assign w_acc  = RV && RR;
  assign w_cons = r_lv && LR;

  assign L  = r_main;
  assign LV = r_lv;

  // Occupancy FSM: moves words between upstream, main and skid; LV is registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_lv    <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main  <= R;
            r_state <= S_ONE;
            r_lv    <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && w_cons) begin
            r_main <= R;
          end else if (w_acc) begin
            r_skid  <= R;
            r_state <= S_TWO;
          end else if (w_cons) begin
            r_state <= S_EMPTY;
            r_lv    <= 1'b0;
          end
        end
        S_TWO: begin
          // Upstream is not ready here, so only a downstream consume moves the skid word forward.
          if (w_cons) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_lv    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IXC_PIPE_STALLCNT_EN
  logic [7:0] r_stall;

  // Count cycles where a valid word waits on downstream, saturating at 255.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall <= '0;
    end else if (r_lv && !LR && (r_stall != 8'hFF)) begin
      r_stall <= r_stall + 8'd1;
    end
  end

  assign STALL = r_stall;
`endif

endmodule

// File: tb/tb_ixc_pipe_21.sv
// Bench for ixc_pipe_21: directed vectors with a scoreboard queue and a decoupled negedge monitor.
// Inputs are driven 1 time unit after the rising edge; all sampling happens on the falling edge.
// The monitor also checks that L is held while stalled and that no word appears without a prior accept.
module tb_ixc_pipe_21;

  logic        CLK;
  logic        RST;
  logic [20:0] R;
  logic        RV;
  logic        RR;
  logic [20:0] L;
  logic        LV;
  logic        LR;
`ifdef IXC_PIPE_STALLCNT_EN
  logic [7:0]  STALL;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [20:0] sb[$];
  logic        have_hold = 1'b0;
  logic [20:0] hold_val  = '0;

  ixc_pipe_21 dut (
    .CLK (CLK),
    .RST (RST),
    .R   (R),
    .RV  (RV),
    .RR  (RR),
    .L   (L),
    .LV  (LV),
    .LR  (LR)
`ifdef IXC_PIPE_STALLCNT_EN
    ,
    .STALL (STALL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold && LV) begin
        check("hold_stable", {11'd0, L}, {11'd0, hold_val});
      end
      if (LV && LR) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_word actual=%0h required=none", L);
        end else begin
          logic [20:0] exp_w;
          exp_w = sb.pop_front();
          chk_cnt--;
          check("out_word", {11'd0, L}, {11'd0, exp_w});
        end
      end
      if (RV && RR) begin
        sb.push_back(R);
      end
      have_hold = LV && !LR;
      hold_val  = L;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    RV  = 1'b0;
    R   = '0;
    LR  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_rr", {31'd0, RR}, 32'd0);
    check("rst_lv", {31'd0, LV}, 32'd0);
    check("rst_l", {11'd0, L}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_rr", {31'd0, RR}, 32'd1);
    check("post_rst_lv", {31'd0, LV}, 32'd0);
    check("post_rst_l", {11'd0, L}, 32'd0);

    // Single word, one-cycle latency
    @(posedge CLK); #1;
    RV = 1'b1; R = 21'h1ABCDE; LR = 1'b1;
    @(posedge CLK); #1;
    RV = 1'b0;
    @(negedge CLK);
    check("single_l", {11'd0, L}, 32'h1ABCDE);
    check("single_lv", {31'd0, LV}, 32'd1);
    @(negedge CLK);
    check("single_lv_after", {31'd0, LV}, 32'd0);

    // Streaming 1..100 with LR held high
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLK); #1;
      RV = 1'b1; R = 21'(i);
      @(negedge CLK);
      check("stream_rr", {31'd0, RR}, 32'd1);
      if (i > 1) begin
        check("stream_l", {11'd0, L}, 32'(i - 1));
        check("stream_lv", {31'd0, LV}, 32'd1);
      end
    end
    @(posedge CLK); #1;
    RV = 1'b0;
    @(negedge CLK);
    check("stream_last_l", {11'd0, L}, 32'd100);
    @(negedge CLK);
    check("stream_end_lv", {31'd0, LV}, 32'd0);

    // Backpressure: fill both entries with LR low
    @(posedge CLK); #1;
    LR = 1'b0; RV = 1'b1; R = 21'h00001;
    @(posedge CLK); #1;
    R = 21'h00002;
    @(posedge CLK); #1;
    RV = 1'b0;
    @(negedge CLK);
    check("bp_rr", {31'd0, RR}, 32'd0);
    check("bp_l", {11'd0, L}, 32'h1);
    check("bp_lv", {31'd0, LV}, 32'd1);
    repeat (3) @(negedge CLK);
    check("bp_l_held", {11'd0, L}, 32'h1);
    check("bp_rr_held", {31'd0, RR}, 32'd0);
    @(posedge CLK); #1;
    LR = 1'b1;
    @(negedge CLK);
    check("bp_drain_l1", {11'd0, L}, 32'h1);
    @(negedge CLK);
    check("bp_drain_l2", {11'd0, L}, 32'h2);
    check("bp_drain_rr", {31'd0, RR}, 32'd1);
    @(negedge CLK);
    check("bp_drain_lv", {31'd0, LV}, 32'd0);

    // Reset while holding two words
    @(posedge CLK); #1;
    LR = 1'b0; RV = 1'b1; R = 21'h00003;
    @(posedge CLK); #1;
    R = 21'h00004;
    @(posedge CLK); #1;
    RV = 1'b0;
    @(negedge CLK);
    check("mr_two_rr", {31'd0, RR}, 32'd0);
    check("mr_two_l", {11'd0, L}, 32'h3);
    @(posedge CLK); #1;
    RST = 1'b1; LR = 1'b1; RV = 1'b1; R = 21'h00055;
    @(negedge CLK);
    check("mr_rst_rr", {31'd0, RR}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; RV = 1'b0;
    @(negedge CLK);
    check("mr_lv", {31'd0, LV}, 32'd0);
    check("mr_l", {11'd0, L}, 32'd0);
    check("mr_rr", {31'd0, RR}, 32'd1);
    repeat (5) @(negedge CLK);
    check("mr_no_stale", {31'd0, LV}, 32'd0);

`ifdef IXC_PIPE_STALLCNT_EN
    // Stall counter saturation and clear
    @(posedge CLK); #1;
    RV = 1'b1; R = 21'h00007; LR = 1'b0;
    @(posedge CLK); #1;
    RV = 1'b0;
    repeat (300) @(posedge CLK);
    @(negedge CLK);
    check("stall_sat", {24'd0, STALL}, 32'd255);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("stall_clr", {24'd0, STALL}, 32'd0);
`endif

    // Drain and confirm every accepted word came out
    @(posedge CLK); #1;
    LR = 1'b1; RV = 1'b0;
    repeat (4) @(negedge CLK);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
